// File: rtl/dma_transfer_ctrl_if.sv
// dma_transfer_ctrl_if: shared Data_bus, memory address/strobes, IO-device handshakes and bus arbitration
interface dma_transfer_ctrl_if #(parameter int DATA_W = 32, parameter int ADDR_W = 9);
    logic grant, bus_req;
    logic [DATA_W-1:0] data_in, data_out;
    logic data_oe;
    logic [ADDR_W-1:0] adress_bus;
    logic memWrite, IOWrite1, IOWrite2;
    logic Ack1, Ack2;
    logic [9:0] index;
    modport master (
        input grant, data_in, Ack1, Ack2,
        output bus_req, data_out, data_oe, adress_bus, memWrite, IOWrite1, IOWrite2, index
    );
    modport slave (
        output grant, data_in, Ack1, Ack2,
        input bus_req, data_out, data_oe, adress_bus, memWrite, IOWrite1, IOWrite2, index
    );
endinterface

// File: rtl/dma_transfer_ctrl.sv
// dma_transfer_ctrl: single-instruction DMA engine moving LEN words between memory and one of two IO devices
module dma_transfer_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int LEN_W = 8,
    parameter int MEM_RD_LAT = 1,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic instr_valid,
    input  logic [25:0] instruction,
    output logic busy,
    output logic done,
    output logic err,
    dma_transfer_ctrl_if.master bus
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int LW = $clog2(MEM_RD_LAT + 2);
    typedef enum logic [3:0] {IDLE, FIN_OK, FIN_ERR, REQ, WAIT_ACK, WR, RD, DRV, NEXT} state_t;
    state_t state, state_nx, start;
    logic to_io, dev, ack, tmo_hit, lat_done;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0] cnt;
    logic [TW-1:0] tmo;
    logic [LW-1:0] lat;
    logic [DATA_W-1:0] dreg;
    logic [1:0] op_in;
    logic unused_rsvd;
    assign op_in = instruction[25:24];
    assign unused_rsvd = ^instruction[5:0];
    assign ack = dev ? bus.Ack2 : bus.Ack1;
    assign tmo_hit = tmo == TW'(ACK_TIMEOUT - 1);
    assign lat_done = lat == LW'(MEM_RD_LAT);
    assign start = to_io ? RD : WAIT_ACK;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            to_io <= 1'b0;
            dev <= 1'b0;
            addr <= '0;
            cnt <= '0;
            tmo <= '0;
            lat <= '0;
            dreg <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && instr_valid) begin
                to_io <= instruction[25];
                dev <= instruction[23];
                addr <= instruction[22:14];
                cnt <= instruction[13:6];
            end
            if (state == NEXT) begin
                addr <= addr + 1'b1;
                cnt <= cnt - 1'b1;
            end
            if ((state == WAIT_ACK && ack) || (state == RD && lat_done))
                dreg <= bus.data_in;
            // timeout runs only while parked on a handshake; any exit clears it
            tmo <= (state_nx == state && (state == WAIT_ACK || state == DRV)) ? tmo + 1'b1 : '0;
            lat <= (state == RD && !lat_done) ? lat + 1'b1 : '0;
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (instr_valid) state_nx = &op_in ? FIN_ERR :
                                       (op_in == 2'b00 || instruction[13:6] == '0) ? FIN_OK : REQ;
            FIN_OK:   state_nx = IDLE;
            FIN_ERR:  state_nx = IDLE;
            REQ:      if (bus.grant) state_nx = start;
            WAIT_ACK: state_nx = ack ? WR : tmo_hit ? FIN_ERR : WAIT_ACK;
            WR:       state_nx = NEXT;
            RD:       if (lat_done) state_nx = DRV;
            DRV:      state_nx = ack ? NEXT : tmo_hit ? FIN_ERR : DRV;
            NEXT:     state_nx = cnt == LEN_W'(1) ? FIN_OK : bus.grant ? start : REQ;
            default:  state_nx = IDLE;
        endcase
        busy = state inside {REQ, WAIT_ACK, WR, RD, DRV, NEXT};
        done = state == FIN_OK;
        err = state == FIN_ERR;
        bus.bus_req = busy;
        // bus drivers are gated by grant so a mid-word grant loss never contends
        bus.data_oe = (state == WR || state == DRV) && bus.grant;
        bus.memWrite = state == WR && bus.grant;
        bus.IOWrite1 = state == DRV && !dev && bus.grant;
        bus.IOWrite2 = state == DRV && dev && bus.grant;
        bus.adress_bus = (state == WR || state == RD) ? addr : '0;
        bus.data_out = dreg;
        bus.index = {dev, 1'b0, addr[7:0]};
    end
endmodule

// File: tb/tb_dma_transfer_ctrl.sv
// tb_dma_transfer_ctrl: directed transfers against a memory model and two IO-device models
module tb_dma_transfer_ctrl;
    localparam int TMO = 8;
    logic clk = 1'b0, rst_n = 1'b0, instr_valid = 1'b0;
    logic [25:0] instruction = '0;
    logic busy, done, err;
    dma_transfer_ctrl_if bif();
    dma_transfer_ctrl #(.ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instruction(instruction),
        .busy(busy), .done(done), .err(err), .bus(bif.master)
    );
    always #5 clk = ~clk;
    logic [31:0] mem [512];
    logic [31:0] rdata;
    logic [31:0] src_w [4];
    int io_k = 0, io_n = 0;
    logic src_en = 1'b0, src_dev = 1'b0, noise2 = 1'b0, grant = 1'b1;
    logic snk_ack1 = 1'b0, snk_ack2 = 1'b0, src_ack;
    logic [31:0] log_d [16];
    logic [9:0] log_i [16];
    int n_log = 0, n_mw = 0, n_iow1 = 0, n_iow2 = 0, n_done = 0, n_err = 0, n_viol = 0;
    int s_log, s_mw, s_iow1, s_iow2, s_done, s_err, s_viol;
    int n_chk = 0, n_fail = 0;
    assign src_ack = src_en && io_k < io_n;
    assign bif.grant = grant;
    assign bif.Ack1 = (src_ack && !src_dev) || snk_ack1;
    assign bif.Ack2 = (src_ack && src_dev) || snk_ack2 || noise2;
    assign bif.data_in = src_ack ? src_w[io_k[1:0]] : rdata;
    always @(posedge clk) begin
        if (bif.memWrite) mem[bif.adress_bus] <= bif.data_out;
        rdata <= mem[bif.adress_bus];
    end
    // device source advances on each memWrite; device sink acks one cycle after seeing its strobe
    always @(negedge clk) begin
        if (!src_en) io_k = 0;
        else if (bif.memWrite) io_k++;
        if (bif.IOWrite1 && !snk_ack1) begin
            log_d[n_log[3:0]] = bif.data_out;
            log_i[n_log[3:0]] = bif.index;
            n_log++;
            snk_ack1 = 1'b1;
        end else snk_ack1 = 1'b0;
        if (bif.IOWrite2 && !snk_ack2) begin
            log_d[n_log[3:0]] = bif.data_out;
            log_i[n_log[3:0]] = bif.index;
            n_log++;
            snk_ack2 = 1'b1;
        end else snk_ack2 = 1'b0;
        n_mw += int'(bif.memWrite);
        n_iow1 += int'(bif.IOWrite1);
        n_iow2 += int'(bif.IOWrite2);
        n_done += int'(done);
        n_err += int'(err);
        if (!bif.grant && (bif.memWrite || bif.IOWrite1 || bif.IOWrite2 || bif.data_oe)) n_viol++;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic snap();
        s_log = n_log; s_mw = n_mw; s_iow1 = n_iow1; s_iow2 = n_iow2;
        s_done = n_done; s_err = n_err; s_viol = n_viol;
    endtask
    task automatic issue(input logic [1:0] op, input logic dev, input logic [8:0] a, input logic [7:0] len);
        @(negedge clk);
        instruction = {op, dev, a, len, 6'd0};
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask
    task automatic src_load(input logic dev, input int n, input logic [31:0] w0, w1, w2, w3);
        src_en = 1'b0;
        repeat (2) @(negedge clk);
        src_w = '{w0, w1, w2, w3};
        io_n = n;
        src_dev = dev;
        src_en = 1'b1;
    endtask
    task automatic wait_done(input string tag);
        int i = 0;
        while (!(done || err) && i < 200) begin
            @(negedge clk);
            i++;
        end
        check({tag, " finished"}, 32'(i < 200), 1);
        @(negedge clk);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end
    initial begin
        int i, n, cyc;
        #3;
        check("reset outputs", 32'(|{busy, done, err, bif.bus_req, bif.data_oe, bif.memWrite,
              bif.IOWrite1, bif.IOWrite2, bif.adress_bus, bif.index, bif.data_out}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // IO1 -> memory, three words
        src_load(1'b0, 3, 32'hA1, 32'hA2, 32'hA3, 32'h0);
        snap();
        issue(2'b01, 1'b0, 9'h010, 8'd3);
        wait_done("t1");
        check("t1 mem[010]", mem[9'h010], 32'hA1);
        check("t1 mem[011]", mem[9'h011], 32'hA2);
        check("t1 mem[012]", mem[9'h012], 32'hA3);
        check("t1 memWrite pulses", n_mw - s_mw, 3);
        check("t1 done pulses", n_done - s_done, 1);
        check("t1 err pulses", n_err - s_err, 0);
        src_en = 1'b0;
        // zero length and illegal op
        snap();
        issue(2'b01, 1'b0, 9'h010, 8'd0);
        check("t3 len0 done", done, 1);
        check("t3 len0 busy", busy, 0);
        check("t3 len0 bus_req", bif.bus_req, 0);
        @(negedge clk);
        check("t3 len0 done width", done, 0);
        check("t3 len0 bus_req later", bif.bus_req, 0);
        issue(2'b11, 1'b0, 9'h010, 8'd2);
        check("t3 illegal err", err, 1);
        check("t3 illegal busy", busy, 0);
        @(negedge clk);
        check("t3 illegal err width", err, 0);
        check("t3 illegal busy later", busy, 0);
        // IO2 -> memory across the address wrap with a 5-cycle grant pause after word 1
        src_load(1'b1, 4, 32'hC1, 32'hC2, 32'hC3, 32'hC4);
        snap();
        issue(2'b01, 1'b1, 9'h1FE, 8'd4);
        i = 0;
        while (!bif.memWrite && i < 50) begin
            @(negedge clk);
            i++;
        end
        check("t4 first word", 32'(i < 50), 1);
        @(negedge clk);
        grant = 1'b0;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            n += int'(bif.bus_req);
        end
        check("t4 bus_req held in pause", n, 5);
        check("t4 words during pause", n_mw - s_mw, 1);
        grant = 1'b1;
        wait_done("t4");
        check("t4 memWrite pulses", n_mw - s_mw, 4);
        check("t4 strobes without grant", n_viol - s_viol, 0);
        check("t4 mem[1FE]", mem[9'h1FE], 32'hC1);
        check("t4 mem[1FF]", mem[9'h1FF], 32'hC2);
        check("t4 mem[000]", mem[9'h000], 32'hC3);
        check("t4 mem[001]", mem[9'h001], 32'hC4);
        check("t4 done pulses", n_done - s_done, 1);
        src_en = 1'b0;
        // memory -> IO2 across the wrap
        snap();
        issue(2'b10, 1'b1, 9'h1FF, 8'd2);
        wait_done("t2");
        check("t2 IOWrite2 pulses", n_iow2 - s_iow2, 2);
        check("t2 IOWrite1 pulses", n_iow1 - s_iow1, 0);
        check("t2 word0 data", log_d[s_log[3:0]], 32'hC2);
        check("t2 word1 data", log_d[4'(s_log + 1)], 32'hC3);
        check("t2 word0 index", 32'(log_i[s_log[3:0]]), 32'h2FF);
        check("t2 word1 index", 32'(log_i[4'(s_log + 1)]), 32'h200);
        check("t2 done pulses", n_done - s_done, 1);
        // ack timeout while Ack2 (not selected) toggles
        snap();
        issue(2'b01, 1'b0, 9'h030, 8'd2);
        cyc = 1;
        while (!err && cyc < 40) begin
            @(negedge clk);
            cyc++;
            noise2 = ~noise2;
        end
        noise2 = 1'b0;
        check("t5 err latency", cyc, 2 + TMO);
        check("t5 busy at err", busy, 0);
        check("t5 bus_req at err", bif.bus_req, 0);
        repeat (2) @(negedge clk);
        check("t5 err pulses", n_err - s_err, 1);
        check("t5 no memWrite", n_mw - s_mw, 0);
        // async reset during DRV of word 2
        snap();
        issue(2'b10, 1'b0, 9'h010, 8'd3);
        n = 0;
        i = 0;
        while (n < 2 && i < 100) begin
            @(negedge clk);
            i++;
            if (bif.IOWrite1) n++;
        end
        check("t6 reached word 2", n, 2);
        rst_n = 1'b0;
        #1;
        check("t6 outputs cleared", 32'(|{busy, done, err, bif.bus_req, bif.data_oe, bif.memWrite,
              bif.IOWrite1, bif.IOWrite2, bif.adress_bus, bif.index, bif.data_out}), 0);
        check("t6 word1 data", log_d[s_log[3:0]], 32'hA1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        src_load(1'b0, 1, 32'hD1, 32'h0, 32'h0, 32'h0);
        snap();
        issue(2'b01, 1'b0, 9'h020, 8'd1);
        wait_done("t6 post-reset");
        check("t6 mem[020]", mem[9'h020], 32'hD1);
        check("t6 memWrite pulses", n_mw - s_mw, 1);
        check("t6 done pulses", n_done - s_done, 1);
        src_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
        $finish;
    end
endmodule
